// File: rtl/button_event_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_event_gen_if : button level in, event pulses/count out.  Rev 1.0
// ---------------------------------------------------------------------------
interface button_event_gen_if;
  logic       button_state;
  logic       press_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       release_pulse;
  logic       held;
  logic [7:0] event_count;

  modport master (
    output button_state,
    input  press_pulse, long_pulse, repeat_pulse, release_pulse, held, event_count
  );

  modport slave (
    input  button_state,
    output press_pulse, long_pulse, repeat_pulse, release_pulse, held, event_count
  );
endinterface
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_event_gen : debounced level -> press/long/repeat/release pulses.
// Auto-repeat enabled by macro BUTTON_AUTO_REPEAT_EN.           Rev 1.0
// ---------------------------------------------------------------------------
module button_event_gen #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic               clk,
  input  logic               reset_n,
  button_event_gen_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] LONG  = 2'd2;

  localparam longint    CNT_RANGE = longint'(1) << CNT_W;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Elaboration-time guard: thresholds must be >= 2 and fit in the counter.
  if ((HOLD_CYCLES < 2) || (REPEAT_CYCLES < 2) ||
      (CNT_RANGE <= longint'(HOLD_CYCLES)) ||
      (CNT_RANGE <= longint'(REPEAT_CYCLES))) begin : g_bad_params
    $error("button_event_gen: illegal HOLD_CYCLES/REPEAT_CYCLES/CNT_W");
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.press_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.held          <= 1'b0;
      bus.event_count   <= 8'd0;
    end else begin
      bus.press_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.button_state) begin
            state           <= PRESS;
            cnt             <= '0;
            bus.press_pulse <= 1'b1;
            bus.event_count <= bus.event_count + 8'd1;
          end
        end
        PRESS: begin
          // Release wins over the hold threshold on the same edge.
          if (!bus.button_state) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
          end else if (cnt == HOLD_LAST) begin
            state          <= LONG;
            cnt            <= '0;
            bus.long_pulse <= 1'b1;
            bus.held       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (!bus.button_state) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
          end else if (cnt == REPEAT_LAST) begin
            cnt              <= '0;
            bus.repeat_pulse <= 1'b1;
            bus.event_count  <= bus.event_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          end else begin
            cnt <= '0;
          end
`endif
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.held <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
